// File: rtl/match_sched_pkg.sv
// match_sched shared types: FSM state encoding and default sizing.
package match_sched_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GRANT = 3'd1,
    SHIFT = 3'd2,
    LAST  = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_NREQ     = 2;
  localparam int DEF_STEP_DIV = 4;

endpackage

// File: rtl/step_tick_gen.sv
// Step divider: one-cycle tick every STEP_DIV clocks, restartable.
module step_tick_gen
  import match_sched_pkg::*;
#(
  parameter int STEP_DIV = DEF_STEP_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick,
  output logic phase0
);

  localparam int DW = $clog2(STEP_DIV);

  logic [DW-1:0] cnt;

  assign tick   = (cnt == DW'(STEP_DIV - 1));
  assign phase0 = (cnt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (restart || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DW'(1);
    end
  end

endmodule

// File: rtl/match_sched.sv
// Round-robin scheduler feeding words bit-serially into a shared
// 011 detector and reporting the hit count per job.
module match_sched
  import match_sched_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int NREQ     = DEF_NREQ,
  parameter int STEP_DIV = DEF_STEP_DIV
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ*WIDTH-1:0]      word_in,
  output logic [NREQ-1:0]            gnt,
  output logic                       det_clr,
  output logic                       det_step,
  output logic                       det_a,
  input  logic                       det_y,
  output logic                       done,
  output logic [$clog2(NREQ)-1:0]    done_id,
  output logic [$clog2(WIDTH+1)-1:0] match_cnt
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(WIDTH + 1);

  state_e state_q, state_d;

  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   pick;
  logic [IDW-1:0]   cur;
  logic             found;
  logic [WIDTH-1:0] sel_word;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    hit_cnt;
  logic [CW-1:0]    bit_idx;
  logic             tick;
  logic             phase0;
  logic             last_step;
  logic             sample;

  step_tick_gen #(
    .STEP_DIV (STEP_DIV)
  ) u_tick (
    .clk     (clk),
    .reset   (reset),
    .restart (state_q == GRANT),
    .tick    (tick),
    .phase0  (phase0)
  );

  // Search upward from the slot after the last winner, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      logic [IDW-1:0] c;
      c = IDW'((int'(ptr) + k) % NREQ);
      if (!found && req[c]) begin
        found = 1'b1;
        pick  = c;
      end
    end
  end

  always_comb begin
    sel_word = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick == IDW'(i)) begin
        sel_word = word_in[i*WIDTH +: WIDTH];
      end
    end
  end

  assign det_clr   = (state_q == GRANT);
  assign det_step  = (state_q == SHIFT) && tick;
  assign det_a     = det_step && shreg[WIDTH-1];
  assign done      = (state_q == DONE);
  assign last_step = det_step && (bit_idx == CW'(WIDTH - 1));
  // det_y is valid the cycle after a step, i.e. divider phase 0.
  assign sample    = (state_q == SHIFT) && phase0 && (bit_idx != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (found) state_d = GRANT;
      GRANT:   state_d = SHIFT;
      SHIFT:   if (last_step) state_d = LAST;
      LAST:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr       <= IDW'(NREQ - 1);
      cur       <= '0;
      gnt       <= '0;
      shreg     <= '0;
      hit_cnt   <= '0;
      bit_idx   <= '0;
      done_id   <= '0;
      match_cnt <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (found) begin
            gnt   <= NREQ'(1) << pick;
            cur   <= pick;
            ptr   <= pick;
            shreg <= sel_word;
          end
        end
        GRANT: begin
          hit_cnt <= '0;
          bit_idx <= '0;
        end
        SHIFT: begin
          if (sample && det_y) begin
            hit_cnt <= hit_cnt + CW'(1);
          end
          if (det_step) begin
            shreg   <= {shreg[WIDTH-2:0], 1'b0};
            bit_idx <= bit_idx + CW'(1);
          end
        end
        LAST: begin
          hit_cnt   <= hit_cnt + CW'(det_y);
          match_cnt <= hit_cnt + CW'(det_y);
          done_id   <= cur;
        end
        DONE: begin
          gnt <= '0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_match_sched.sv
// Directed bench for match_sched with a behavioural 011 detector attached.
module tb_match_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req;
  logic [15:0] word_in;
  logic [1:0]  gnt;
  logic        det_clr;
  logic        det_step;
  logic        det_a;
  logic        det_y;
  logic        done;
  logic [0:0]  done_id;
  logic [3:0]  match_cnt;

  int n_vec = 0;
  int n_bad = 0;

  logic [1:0] ds = 2'd0;
  logic [7:0] stream = 8'd0;
  int         nsteps = 0;
  int         viol = 0;
  int         ndone = 0;

  always #5 clk = ~clk;

  match_sched dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .word_in   (word_in),
    .gnt       (gnt),
    .det_clr   (det_clr),
    .det_step  (det_step),
    .det_a     (det_a),
    .det_y     (det_y),
    .done      (done),
    .done_id   (done_id),
    .match_cnt (match_cnt)
  );

  // 011 detector: S0 init, S1 saw 0, S2 saw 01, S3 saw 011 (y=1).
  always @(posedge clk) begin
    if (det_clr) begin
      ds <= 2'd0;
    end else if (det_step) begin
      case (ds)
        2'd0:    ds <= det_a ? 2'd0 : 2'd1;
        2'd1:    ds <= det_a ? 2'd2 : 2'd1;
        2'd2:    ds <= det_a ? 2'd3 : 2'd1;
        default: ds <= det_a ? 2'd0 : 2'd1;
      endcase
    end
  end
  assign det_y = (ds == 2'd3);

  always @(negedge clk) begin
    if (det_clr) begin
      stream = 8'd0;
      nsteps = 0;
    end
    if (det_step) begin
      stream = {stream[6:0], det_a};
      nsteps++;
    end
    if (det_step && det_clr) viol++;
    if (!$onehot0(gnt)) viol++;
    if (done) ndone++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_job(input logic [1:0] r, input logic [7:0] w0,
                         input logic [7:0] w1, input int id,
                         input logic [7:0] exp_word, input int cnt,
                         input bit drop, input bit late);
    int cyc;
    logic [1:0] g0;
    bit stable;
    @(negedge clk);
    req = r;
    word_in = {w1, w0};
    cyc = 0;
    while (gnt == 2'b00 && cyc < 5) begin
      @(negedge clk);
      cyc++;
    end
    chk("gnt", gnt, 2'b01 << id);
    chk("det_clr_grant", det_clr, 1'b1);
    g0 = gnt;
    stable = 1'b1;
    word_in = ~{w1, w0};
    if (drop) req = 2'b00;
    cyc = 1;
    while (!done && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (cyc == 10 && late) req = 2'b11;
      if (gnt !== g0) stable = 1'b0;
    end
    chk("done_cycle", cyc, 35);
    chk("done_id", done_id, id);
    chk("match_cnt", match_cnt, cnt);
    chk("det_a_seq", stream, exp_word);
    chk("step_count", nsteps, 8);
    chk("gnt_stable", stable, 1'b1);
  endtask

  initial begin
    int k;
    int nd;
    reset = 1'b1;
    req = 2'b00;
    word_in = 16'h0000;
    repeat (2) @(negedge clk);
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_done", done, 1'b0);
    chk("rst_step", det_step, 1'b0);
    chk("rst_clr", det_clr, 1'b0);
    chk("rst_cnt", match_cnt, 4'd0);
    chk("rst_id", done_id, 1'b0);
    reset = 1'b0;

    run_job(2'b11, 8'h6C, 8'h33, 0, 8'h6C, 2, 1'b0, 1'b0);
    run_job(2'b11, 8'h6C, 8'h33, 1, 8'h33, 2, 1'b0, 1'b0);
    run_job(2'b11, 8'h6C, 8'h33, 0, 8'h6C, 2, 1'b0, 1'b0);
    run_job(2'b11, 8'h6C, 8'h33, 1, 8'h33, 2, 1'b0, 1'b0);

    run_job(2'b01, 8'hFF, 8'h00, 0, 8'hFF, 0, 1'b0, 1'b0);
    run_job(2'b01, 8'h33, 8'h00, 0, 8'h33, 2, 1'b0, 1'b0);
    run_job(2'b01, 8'h55, 8'h00, 0, 8'h55, 0, 1'b1, 1'b0);
    run_job(2'b01, 8'hFF, 8'h6C, 0, 8'hFF, 0, 1'b0, 1'b1);
    run_job(2'b10, 8'h00, 8'h33, 1, 8'h33, 2, 1'b0, 1'b0);

    @(negedge clk);
    req = 2'b01;
    word_in = 16'h006C;
    k = 0;
    nd = 0;
    while (k < 4 && nd < 60) begin
      @(negedge clk);
      nd++;
      if (det_step) k++;
    end
    chk("reach_step4", k, 4);
    req = 2'b00;
    reset = 1'b1;
    #1;
    chk("mid_rst_gnt", gnt, 2'b00);
    chk("mid_rst_step", det_step, 1'b0);
    chk("mid_rst_a", det_a, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_cnt", match_cnt, 4'd0);
    nd = ndone;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("no_done_after_rst", ndone, nd);

    run_job(2'b01, 8'h6C, 8'h00, 0, 8'h6C, 2, 1'b0, 1'b0);

    @(negedge clk);
    chk("monitor_violations", viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
